// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first: synchronises the line, validates the start bit at
// its midpoint and samples each following bit mid-period, strobing good bytes out.
module uart_recv #(
    parameter int CLK  = 50000000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       UART_rx,
    output logic [7:0] data_out,
    output logic       flag_out,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_CNT = CLK / BAUD;
    localparam int HALF     = BAUD_CNT / 2;
    localparam int CNT_W    = $clog2(BAUD_CNT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             flag_n, ferr_n;
    logic             rx_m, rx_s, rx_d;
    logic             start_edge;

    // Resetting the chain to 0 means a line held low through reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
            rx_d <= 1'b0;
        end else begin
            rx_m <= UART_rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_out  <= '0;
            flag_out  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            data_out  <= data_n;
            flag_out  <= flag_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = data_out;
        flag_n    = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start_edge) begin
                    state_n = START;
                end
            end

            // A start bit that is high again at its midpoint was only a glitch.
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_cnt] = rx_s;
                    bit_cnt_n        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Leaving at mid stop bit frees the receiver for a zero-gap following frame.
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n = shift;
                        flag_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: table of framed bytes, hand sequences for glitch, break,
// back-to-back and reset corners, plus random frames checked against a byte-queue model.
module tb_uart_recv;

    localparam int BIT_T   = 50000000 / 115200;
    localparam int HALF_T  = BIT_T / 2;
    localparam int LATENCY = HALF_T + 9 * BIT_T;

    logic       clk;
    logic       rstn;
    logic       UART_rx;
    logic [7:0] data_out;
    logic       flag_out;
    logic       frame_err;
    logic       busy;

    uart_recv dut (
        .clk      (clk),
        .rstn     (rstn),
        .UART_rx  (UART_rx),
        .data_out (data_out),
        .flag_out (flag_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop_bit;
        int         break_len;
        int         exp_flags;
        int         exp_ferrs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    // Monitor state: written only by the monitor, read by the checking process.
    int         cycle = 0;
    int         start_cycle = 0;
    int         busy_cycles = 0;
    int         ferr_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_busy = 1'b0;
    logic       prev_flag = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] got_q[$];
    int         lat_q[$];

    // Reference model and bookkeeping owned by the main process.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         exp_ferr = 0;
    int         got_rd = 0;
    int         lat_rd = 0;
    int         checks = 0;
    int         passes = 0;

    always @(negedge clk) begin
        cycle++;
        if (rstn) begin
            if (busy && !prev_busy) start_cycle = cycle;
            if (busy) busy_cycles++;
            if (flag_out) begin
                got_q.push_back(data_out);
                lat_q.push_back(cycle - start_cycle);
            end
            if (frame_err) lat_q.push_back(cycle - start_cycle);
            if (frame_err) ferr_cnt++;
            if (flag_out && frame_err) overlap_cnt++;
            if ((flag_out && prev_flag) || (frame_err && prev_ferr)) wide_cnt++;
            prev_busy = busy;
            prev_flag = flag_out;
            prev_ferr = frame_err;
        end else begin
            prev_busy = 1'b0;
            prev_flag = 1'b0;
            prev_ferr = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        UART_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
        drive_bit(stop_bit, period);
    endtask

    // Model: a good stop bit delivers the byte, a bad one only counts a frame error.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int idle_busy);
        int base;
        model_frame(v.data, v.stop_bit);
        send_frame(v.data, v.period, v.stop_bit);
        base = busy_cycles;
        if (v.break_len > 0) drive_bit(1'b0, v.break_len);
        drive_bit(1'b1, 100);
        idle_busy = busy_cycles - base;
    endtask

    task automatic compare_phase(input string name);
        int waited;
        waited = 0;
        while (busy && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " busy_idle"}, int'(busy), 0);
        while (got_rd < got_q.size()) begin
            if (exp_q.size() == 0) begin
                checkOutput({name, " unexpected_flag"}, int'(got_q[got_rd]), -1);
            end else begin
                checkOutput({name, " byte"}, int'(got_q[got_rd]), int'(exp_q.pop_front()));
            end
            got_rd++;
        end
        checkOutput({name, " missing_bytes"}, exp_q.size(), 0);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        while (lat_rd < lat_q.size()) begin
            checkOutput({name, " latency"}, lat_q[lat_rd], LATENCY);
            lat_rd++;
        end
        checkOutput({name, " frame_err_count"}, ferr_cnt, exp_ferr);
        checkOutput({name, " data_out"}, int'(data_out), int'(last_good));
    endtask

    initial begin
        int         idle_busy;
        int         base;
        logic [7:0] msg[9];
        logic [7:0] rb;
        logic       rs;

        vecs[0] = '{8'h55, BIT_T, 1'b1, 0,    1, 0, 8'h55};
        vecs[1] = '{8'hA5, BIT_T, 1'b0, 2000, 0, 1, 8'h55};
        vecs[2] = '{8'h12, BIT_T, 1'b1, 0,    1, 0, 8'h12};
        vecs[3] = '{8'h3C, 447,   1'b1, 0,    1, 0, 8'h3C};
        vecs[4] = '{8'hC3, 421,   1'b1, 0,    1, 0, 8'hC3};
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h31, 8'h32, 8'h33, 8'h0A};

        UART_rx = 1'b1;
        rstn    = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset data_out", int'(data_out), 0);
        checkOutput("reset flag_out", int'(flag_out), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset busy", int'(busy), 0);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            int flags_before;
            int ferr_before;
            flags_before = got_q.size();
            ferr_before  = ferr_cnt;
            applyStimulus(vecs[i], idle_busy);
            checkOutput($sformatf("vec%0d flags", i), got_q.size() - flags_before, vecs[i].exp_flags);
            checkOutput($sformatf("vec%0d frame_errs", i), ferr_cnt - ferr_before, vecs[i].exp_ferrs);
            checkOutput($sformatf("vec%0d data", i), int'(data_out), int'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d idle_busy", i), idle_busy, 0);
            compare_phase($sformatf("vec%0d", i));
        end

        $display("[TB] glitch on idle line");
        base = busy_cycles;
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 500);
        checkOutput("glitch busy_cycles", busy_cycles - base, HALF_T);
        compare_phase("glitch");

        $display("[TB] back-to-back HELLO123");
        for (int i = 0; i < 9; i++) begin
            model_frame(msg[i], 1'b1);
            send_frame(msg[i], $urandom_range(425, 443), 1'b1);
        end
        drive_bit(1'b1, 100);
        compare_phase("hello");

        $display("[TB] random frames");
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            model_frame(rb, rs);
            send_frame(rb, $urandom_range(421, 447), rs);
            drive_bit(1'b1, rs ? $urandom_range(0, 60) : $urandom_range(5, 60));
        end
        drive_bit(1'b1, 100);
        compare_phase("random");

        $display("[TB] reset mid-frame");
        base = got_q.size();
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_T);
        UART_rx = 1'b0;
        rstn    = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midreset data_out", int'(data_out), 0);
        checkOutput("midreset flag_out", int'(flag_out), 0);
        checkOutput("midreset frame_err", int'(frame_err), 0);
        checkOutput("midreset busy", int'(busy), 0);
        last_good = 8'h00;
        rstn = 1'b1;
        idle_busy = busy_cycles;
        drive_bit(1'b0, 500);
        checkOutput("low_after_reset busy_cycles", busy_cycles - idle_busy, 0);
        checkOutput("low_after_reset flags", got_q.size() - base, 0);
        drive_bit(1'b1, 100);
        model_frame(8'h0F, 1'b1);
        send_frame(8'h0F, BIT_T, 1'b1);
        drive_bit(1'b1, 100);
        compare_phase("after_reset");

        checkOutput("strobe overlap", overlap_cnt, 0);
        checkOutput("strobe width", wide_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
